// File: rtl/bp_cfg_loader_pkg.sv
// Shared types and sizing helpers for the configuration loader.
// Entry 0 of the table is reserved as the invalid configuration.
package bp_cfg_loader_pkg;

  typedef enum logic [1:0] {
    e_idle,
    e_send,
    e_done
  } bp_cfg_loader_state_e;

  localparam int invalid_cfg_c = 0;

  function automatic int num_words(
    input int cfg_width,
    input int word_width
  );
    return (cfg_width + word_width - 1)
      / word_width;
  endfunction

  // Never narrower than one bit, even for a single entry.
  function automatic int idx_width(
    input int n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_cfg_serializer.sv
// Holds the latched record and walks it out one
// zero-padded word at a time.
module bp_cfg_serializer
  import bp_cfg_loader_pkg::*;
#(
  parameter int cfg_width_p = 512,
  parameter int word_width_p = 64,
  localparam int words_lp =
    num_words(cfg_width_p, word_width_p),
  localparam int idx_w_lp = idx_width(words_lp)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    load_i,
  input  logic [cfg_width_p-1:0]  record_i,
  input  logic                    adv_i,
  output logic [word_width_p-1:0] word_o,
  output logic [idx_w_lp-1:0]     idx_o,
  output logic                    last_o
);

  localparam int pad_w_lp =
    words_lp * word_width_p;
  localparam logic [idx_w_lp-1:0] last_idx_lp =
    idx_w_lp'(words_lp - 1);

  logic [cfg_width_p-1:0] rec_q;
  logic [idx_w_lp-1:0]    idx_q;
  logic [pad_w_lp-1:0]    padded;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rec_q <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      rec_q <= record_i;
      idx_q <= '0;
    end else if (adv_i) begin
      idx_q <= last_o ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    padded = '0;
    padded[cfg_width_p-1:0] = rec_q;
  end

  assign word_o =
    padded[idx_q*word_width_p +: word_width_p];
  assign idx_o  = idx_q;
  assign last_o = (idx_q == last_idx_lp);

endmodule

// File: rtl/bp_cfg_loader.sv
// Selects a config record, latches it and streams it as
// words to every core in turn, or once as a broadcast.
module bp_cfg_loader
  import bp_cfg_loader_pkg::*;
#(
  parameter int num_cfgs_p = 16,
  parameter int cfg_width_p = 512,
  parameter int word_width_p = 64,
  parameter int num_core_p = 4,
  localparam int sel_w_lp = idx_width(num_cfgs_p),
  localparam int core_w_lp = idx_width(num_core_p),
  localparam int words_lp =
    num_words(cfg_width_p, word_width_p),
  localparam int idx_w_lp = idx_width(words_lp)
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic [num_cfgs_p*cfg_width_p-1:0]
               cfg_table_i,
  input  logic [sel_w_lp-1:0]     cfg_sel_i,
  input  logic                    bcast_i,
  input  logic                    start_i,
  output logic [word_width_p-1:0] data_o,
  output logic [core_w_lp-1:0]    core_id_o,
  output logic                    bcast_o,
  output logic [idx_w_lp-1:0]     word_idx_o,
  output logic                    v_o,
  input  logic                    ready_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam logic [core_w_lp-1:0] last_core_lp =
    core_w_lp'(num_core_p - 1);

  bp_cfg_loader_state_e state_q, state_d;

  logic [core_w_lp-1:0]    core_q;
  logic                    bcast_q;
  logic                    err_q;
  logic                    sel_nz;
  logic                    sel_in_range;
  logic                    sel_ok;
  logic                    in_idle;
  logic                    accept;
  logic                    xfer;
  logic                    last_word;
  logic                    last_core;
  logic                    final_xfer;
  logic [cfg_width_p-1:0]  sel_rec;
  logic [word_width_p-1:0] word;
  logic [idx_w_lp-1:0]     word_idx;

  assign sel_nz =
    (cfg_sel_i != sel_w_lp'(invalid_cfg_c));

  if ((1 << sel_w_lp) == num_cfgs_p) begin : g_pow2
    assign sel_in_range = 1'b1;
  end else begin : g_npow2
    assign sel_in_range =
      32'(cfg_sel_i) < num_cfgs_p;
  end

  assign sel_ok  = sel_nz & sel_in_range;
  assign in_idle = (state_q == e_idle);
  assign accept  = in_idle & start_i & sel_ok;

  assign sel_rec =
    cfg_table_i[cfg_sel_i*cfg_width_p +: cfg_width_p];

  assign v_o        = (state_q == e_send);
  assign xfer       = v_o & ready_i;
  assign last_core  = bcast_q | (core_q == last_core_lp);
  assign final_xfer = xfer & last_word & last_core;

  bp_cfg_serializer #(
    .cfg_width_p  (cfg_width_p),
    .word_width_p (word_width_p)
  ) u_ser (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load_i    (accept),
    .record_i  (sel_rec),
    .adv_i     (xfer),
    .word_o    (word),
    .idx_o     (word_idx),
    .last_o    (last_word)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      core_q  <= '0;
      bcast_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_idle && start_i) begin
        err_q <= ~sel_ok;
      end
      // Counter returns to 0 after the final word.
      if (accept) begin
        core_q  <= '0;
        bcast_q <= bcast_i;
      end else if (xfer && last_word) begin
        core_q <= last_core ? '0 : core_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      e_idle:  if (accept) state_d = e_send;
      e_send:  if (final_xfer) state_d = e_done;
      e_done:  state_d = e_idle;
      default: state_d = e_idle;
    endcase
  end

  assign data_o     = v_o ? word : '0;
  assign word_idx_o = word_idx;
  assign core_id_o  = core_q;
  assign bcast_o    = v_o & bcast_q;
  assign busy_o     = ~in_idle;
  assign done_o     = (state_q == e_done);
  assign err_o      = err_q;

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Directed bench for bp_cfg_loader with small parameters.
// Inputs change 1ns after posedge; outputs sampled there.
module tb_bp_cfg_loader;

  localparam int CW = 100;
  localparam int WW = 32;
  localparam int NC = 4;
  localparam int NF = 4;

  logic          clk = 1'b0;
  logic          reset_n_i = 1'b0;
  logic [NF*CW-1:0] tbl;
  logic [1:0]    cfg_sel_i = '0;
  logic          bcast_i = 1'b0;
  logic          start_i = 1'b0;
  logic          ready_i = 1'b1;
  logic [WW-1:0] data_o;
  logic [1:0]    core_id_o;
  logic          bcast_o;
  logic [1:0]    word_idx_o;
  logic          v_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  int errors = 0;
  int checks = 0;

  logic [WW-1:0] got_d[$];
  logic [1:0]    got_c[$];
  logic [1:0]    got_i[$];
  logic          got_b[$];
  int  viol, done_cnt, done_cyc, xfer_cyc;
  bit  timeout, first_v, busy_after;

  logic [31:0] exp2 [4] = '{32'h12345678,
    32'hCAFEF00D, 32'hDEADBEEF, 32'h0};
  logic [31:0] exp3 [4] = '{32'h55556666,
    32'h33334444, 32'h11112222, 32'h0000000A};

  localparam logic [CW-1:0] E2 =
    100'h0_DEADBEEF_CAFEF00D_12345678;
  localparam logic [CW-1:0] E3 =
    100'hA_11112222_33334444_55556666;

  always #5 clk = ~clk;

  bp_cfg_loader #(
    .num_cfgs_p   (NF),
    .cfg_width_p  (CW),
    .word_width_p (WW),
    .num_core_p   (NC)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n_i),
    .cfg_table_i (tbl),
    .cfg_sel_i   (cfg_sel_i),
    .bcast_i     (bcast_i),
    .start_i     (start_i),
    .data_o      (data_o),
    .core_id_o   (core_id_o),
    .bcast_o     (bcast_o),
    .word_idx_o  (word_idx_o),
    .v_o         (v_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] sel,
                          input logic bc);
    cfg_sel_i = sel;
    bcast_i   = bc;
    start_i   = 1'b1;
    step();
    start_i   = 1'b0;
  endtask

  // Records every accepted word; flags stall instability.
  task automatic collect(input bit rnd, input int poke);
    bit stalled;
    logic [WW-1:0] hd;
    logic [1:0] hc, hi;
    logic hb;
    got_d.delete(); got_c.delete();
    got_i.delete(); got_b.delete();
    viol = 0; done_cnt = 0; done_cyc = -1;
    xfer_cyc = -1; timeout = 1'b1;
    first_v = v_o; busy_after = 1'b1;
    stalled = 1'b0;
    hd = '0; hc = '0; hi = '0; hb = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (stalled && (!v_o || data_o !== hd ||
          core_id_o !== hc || word_idx_o !== hi ||
          bcast_o !== hb))
        viol++;
      if (c == poke) begin
        start_i = 1'b1;
        cfg_sel_i = 2'd1;
        bcast_i = 1'b1;
        tbl[2*CW +: CW] = '1;
      end else if (c == poke + 1) begin
        start_i = 1'b0;
      end
      stalled = 1'b0;
      if (v_o) begin
        ready_i = rnd ? 1'($urandom_range(0, 1))
                      : 1'b1;
        if (ready_i) begin
          got_d.push_back(data_o);
          got_c.push_back(core_id_o);
          got_i.push_back(word_idx_o);
          got_b.push_back(bcast_o);
          xfer_cyc = c;
        end else begin
          stalled = 1'b1;
          hd = data_o; hc = core_id_o;
          hi = word_idx_o; hb = bcast_o;
        end
      end else begin
        ready_i = 1'b1;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = c;
        step();
        busy_after = busy_o;
        if (done_o) done_cnt++;
        timeout = 1'b0;
        break;
      end
      step();
    end
    ready_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    step(); step();
    checks++;
    if ({v_o, busy_o, done_o, err_o, bcast_o}
        !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000",
        {v_o, busy_o, done_o, err_o, bcast_o});
    end
    checks++;
    if (data_o !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0",
        data_o);
    end
    checks++;
    if ({core_id_o, word_idx_o} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ids: got %b want 0000",
        {core_id_o, word_idx_o});
    end
    reset_n_i = 1'b1;
    step();
  endtask

  task automatic test_unicast();
    do_start(2'd2, 1'b0);
    collect(1'b0, -1);
    checks++;
    if (timeout || first_v !== 1'b1) begin
      errors++;
      $display("FAIL uni_start: got to=%0d v=%b want 0 1",
        timeout, first_v);
    end
    checks++;
    if (got_d.size() != 16) begin
      errors++;
      $display("FAIL uni_count: got %0d want 16",
        got_d.size());
    end
    for (int k = 0; k < 16 && k < got_d.size(); k++) begin
      checks++;
      if (got_d[k] !== exp2[k%4] ||
          got_c[k] !== 2'(k/4) ||
          got_i[k] !== 2'(k%4) || got_b[k] !== 1'b0) begin
        errors++;
        $display("FAIL uni_word%0d: got %h c%0d i%0d b%b want %h c%0d i%0d b0",
          k, got_d[k], got_c[k], got_i[k], got_b[k],
          exp2[k%4], k/4, k%4);
      end
    end
    checks++;
    if (xfer_cyc != 15 || done_cyc != 16 ||
        done_cnt != 1 || busy_after !== 1'b0) begin
      errors++;
      $display("FAIL uni_done: got x%0d d%0d n%0d b%b want x15 d16 n1 b0",
        xfer_cyc, done_cyc, done_cnt, busy_after);
    end
  endtask

  task automatic test_bcast();
    do_start(2'd2, 1'b1);
    collect(1'b0, -1);
    checks++;
    if (got_d.size() != 4 || timeout) begin
      errors++;
      $display("FAIL bc_count: got %0d want 4",
        got_d.size());
    end
    for (int k = 0; k < 4 && k < got_d.size(); k++) begin
      checks++;
      if (got_d[k] !== exp2[k] || got_c[k] !== 2'd0 ||
          got_i[k] !== 2'(k) || got_b[k] !== 1'b1) begin
        errors++;
        $display("FAIL bc_word%0d: got %h c%0d i%0d b%b want %h c0 i%0d b1",
          k, got_d[k], got_c[k], got_i[k], got_b[k],
          exp2[k], k);
      end
    end
    checks++;
    if (done_cyc != 4 || done_cnt != 1 ||
        busy_after !== 1'b0) begin
      errors++;
      $display("FAIL bc_done: got d%0d n%0d b%b want d4 n1 b0",
        done_cyc, done_cnt, busy_after);
    end
    bcast_i = 1'b0;
  endtask

  task automatic test_backpressure();
    do_start(2'd2, 1'b0);
    collect(1'b1, -1);
    checks++;
    if (got_d.size() != 16 || timeout ||
        viol != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL bp_stream: got n%0d v%0d d%0d want n16 v0 d1",
        got_d.size(), viol, done_cnt);
    end
    for (int k = 0; k < 16 && k < got_d.size(); k++) begin
      checks++;
      if (got_d[k] !== exp2[k%4] ||
          got_c[k] !== 2'(k/4) ||
          got_i[k] !== 2'(k%4)) begin
        errors++;
        $display("FAIL bp_word%0d: got %h c%0d i%0d want %h c%0d i%0d",
          k, got_d[k], got_c[k], got_i[k],
          exp2[k%4], k/4, k%4);
      end
    end
  endtask

  task automatic test_invalid();
    int bad;
    do_start(2'd0, 1'b0);
    checks++;
    if ({err_o, v_o, busy_o} !== 3'b100) begin
      errors++;
      $display("FAIL inv_err: got %b want 100",
        {err_o, v_o, busy_o});
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (v_o || busy_o || !err_o) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL inv_hold: got %0d bad cycles want 0",
        bad);
    end
    do_start(2'd3, 1'b0);
    checks++;
    if ({err_o, v_o} !== 2'b01) begin
      errors++;
      $display("FAIL inv_clear: got %b want 01",
        {err_o, v_o});
    end
    collect(1'b0, -1);
    checks++;
    if (got_d.size() != 16 || timeout) begin
      errors++;
      $display("FAIL inv_count: got %0d want 16",
        got_d.size());
    end
    for (int k = 0; k < 16 && k < got_d.size(); k++) begin
      checks++;
      if (got_d[k] !== exp3[k%4] ||
          got_i[k] !== 2'(k%4)) begin
        errors++;
        $display("FAIL e3_word%0d: got %h i%0d want %h i%0d",
          k, got_d[k], got_i[k], exp3[k%4], k%4);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_start(2'd2, 1'b0);
    ready_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if ({v_o, core_id_o, word_idx_o} !== 5'b1_01_01) begin
      errors++;
      $display("FAIL mid_pos: got %b want 10101",
        {v_o, core_id_o, word_idx_o});
    end
    reset_n_i = 1'b0;
    step();
    checks++;
    if ({v_o, busy_o, done_o, err_o, bcast_o,
         core_id_o, word_idx_o} !== 9'b0 ||
        data_o !== '0) begin
      errors++;
      $display("FAIL mid_reset: got %b d=%h want 0",
        {v_o, busy_o, done_o, err_o, bcast_o,
         core_id_o, word_idx_o}, data_o);
    end
    reset_n_i = 1'b1;
    step();
    checks++;
    if (done_o || v_o) begin
      errors++;
      $display("FAIL mid_nodone: got d%b v%b want 0 0",
        done_o, v_o);
    end
    do_start(2'd2, 1'b0);
    collect(1'b0, -1);
    checks++;
    if (got_d.size() != 16 || timeout) begin
      errors++;
      $display("FAIL mid_count: got %0d want 16",
        got_d.size());
    end
    for (int k = 0; k < 16 && k < got_d.size(); k++) begin
      checks++;
      if (got_d[k] !== exp2[k%4] ||
          got_c[k] !== 2'(k/4) ||
          got_i[k] !== 2'(k%4)) begin
        errors++;
        $display("FAIL mid_word%0d: got %h c%0d i%0d want %h c%0d i%0d",
          k, got_d[k], got_c[k], got_i[k],
          exp2[k%4], k/4, k%4);
      end
    end
  endtask

  task automatic test_busy_start();
    do_start(2'd2, 1'b0);
    collect(1'b0, 6);
    checks++;
    if (got_d.size() != 16 || timeout ||
        done_cnt != 1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_stream: got n%0d d%0d e%b want n16 d1 e0",
        got_d.size(), done_cnt, err_o);
    end
    for (int k = 0; k < 16 && k < got_d.size(); k++) begin
      checks++;
      if (got_d[k] !== exp2[k%4] ||
          got_c[k] !== 2'(k/4) || got_b[k] !== 1'b0) begin
        errors++;
        $display("FAIL busy_word%0d: got %h c%0d b%b want %h c%0d b0",
          k, got_d[k], got_c[k], got_b[k],
          exp2[k%4], k/4);
      end
    end
    tbl[2*CW +: CW] = E2;
    bcast_i = 1'b0;
    step();
  endtask

  initial begin
    tbl = '0;
    tbl[0*CW +: CW] = {4'h5, {3{32'hA5A5A5A5}}};
    tbl[1*CW +: CW] =
      100'h1_0000000F_0000000E_0000000D;
    tbl[2*CW +: CW] = E2;
    tbl[3*CW +: CW] = E3;
    test_reset();
    test_unicast();
    test_bcast();
    test_backpressure();
    test_invalid();
    test_reset_mid();
    test_busy_start();
    $display("Result: errors=%0d of %0d checks",
      errors, checks);
    $finish;
  end

endmodule

// File: doc/bp_cfg_loader.md
# bp_cfg_loader

Sequential configuration distributor for multicore BlackParrot: selects one entry from a table of packed processor-parameter records, latches it, and streams it as fixed-width words over a valid/ready channel to each core tile, or once as a broadcast. Sits between the top-level configuration source and the per-tile config receivers. Generalises the static, compile-time config table to runtime selection, multiple cores, arbitrary record width and two delivery modes.

## Interface
- num_cfgs_p, 16: table entries; entry 0 is the invalid config.
- cfg_width_p, 512: packed record width in bits.
- word_width_p, 64: output word width.
- num_core_p, 4: destination cores, ≥1.
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; synchronous, active-low, the block's only reset.
- cfg_table_i  in  num_cfgs_p*cfg_width_p  flattened table; entry k at bits [k*cfg_width_p +: cfg_width_p].
- cfg_sel_i  in  clog2(num_cfgs_p)  selected entry.
- bcast_i  in  1  1 = broadcast once, 0 = unicast to each core.
- start_i  in  1  start pulse; sampled only in IDLE.
- data_o  out  word_width_p  current word.
- core_id_o  out  clog2(num_core_p)  destination core; 0 in broadcast.
- bcast_o  out  1  word is a broadcast.
- word_idx_o  out  clog2(num_words)  word index within record.
- v_o  out  1  word valid.
- ready_i  in  1  receiver accepts.
- busy_o  out  1  not IDLE.
- done_o  out  1  one-cycle pulse after the last word is accepted.
- err_o  out  1  sticky; set by an invalid selection.

## Operation
- num_words = ceil(cfg_width_p/word_width_p); the top of the last word is zero-padded.
- States: IDLE, SEND, DONE.
- IDLE: on start_i, if cfg_sel_i==0 or cfg_sel_i≥num_cfgs_p, set err_o, stay in IDLE, emit nothing. Otherwise latch the selected record and bcast_i, clear err_o, clear the counters, go to SEND.
- SEND: v_o=1. data_o = latched record word word_idx_o. A transfer occurs when v_o&ready_i. On a transfer:
  - word_idx increments.
  - At the last word, word_idx wraps to 0 and core_id increments.
  - Exit on the last word of core num_core_p-1 in unicast, or of the single pass in broadcast; go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- start_i outside IDLE is ignored.
- Changes to cfg_table_i or cfg_sel_i after the latch have no effect.
- The latched record is held until the next accepted start.

## Timing
- Reset values: v_o=0, busy_o=0, done_o=0, err_o=0, data_o=0, core_id_o=0, word_idx_o=0, bcast_o=0; state IDLE.
- A reset asserted mid-SEND aborts the stream. v_o is 0 from the next edge; no done_o is produced.
- start_i accepted at edge t puts the first word on v_o at cycle t+1.
- Full throughput: one word per cycle while ready_i=1.
- Total cycles with ready always high: num_words×num_core_p in unicast, num_words in broadcast.
- While v_o=1 and ready_i=0, data_o, core_id_o, word_idx_o and bcast_o are stable. v_o never drops before the transfer completes.
- done_o rises the cycle after the final transfer. busy_o falls the cycle after done_o.
- err_o is updated on the edge that samples start_i.

## Structure
- Shared package bp_cfg_loader_pkg holds:
  - state enum bp_cfg_loader_state_e;
  - function num_words(cfg_width, word_width);
  - constant invalid-config index 0.
- Sub-module bp_cfg_serializer: latched record plus word-index counter and mux, producing a zero-padded word.
- The top level holds the FSM, core counter and error logic.

## Test plan
- Test parameters for all scenarios: cfg_width_p=100, word_width_p=32, num_core_p=4, num_cfgs_p=4. Table entry 2 = 100'h0_DEADBEEF_CAFEF00D_12345678.
- Unicast, ready=1: sel=2, bcast=0, start → 16 words, idx 0..3 per core 0..3. Words are 0x12345678, 0xCAFEF00D, 0xDEADBEEF, 0x0 (padded). done_o 1 cycle later.
- Broadcast: same start with bcast=1 → 4 words, core_id_o=0, bcast_o=1. done_o follows idx 3.
- Backpressure: ready_i random 50% → outputs stable while stalled, same 16-word sequence, no drops or duplicates.
- Invalid select: sel=0 → err_o=1, v_o stays 0, busy_o stays 0. A later sel=3 start clears err_o and streams.
- Reset mid-stream: reset_n_i low at word 5 → all outputs are reset values next cycle. A new start replays from core 0, idx 0.
- Start while busy plus table change: pulse start and change entry 2 during SEND → ignored. Streamed data matches the originally latched record.
